// File: rtl/wino_pkg.sv
// Shared widths and Winograd F(2,3) transform helpers for the engine and its lane.
// Helpers work on 64-bit signed values; callers sign-extend in and size-cast out.
package wino_pkg;

    typedef logic signed [63:0] wide_t;

    function automatic int ow_width(input int dw, input int ch);
        return 2 * dw + 4 + $clog2(ch);
    endfunction

    function automatic int idx_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Filter transform, 2x-scaled so every coefficient stays an integer
    function automatic wide_t filt_xform(input int i, input wide_t g0, input wide_t g1,
                                         input wide_t g2);
        case (i)
            0:       return g0 + g0;
            1:       return g0 + g1 + g2;
            2:       return g0 - g1 + g2;
            default: return g2 + g2;
        endcase
    endfunction

    function automatic wide_t data_xform(input int i, input wide_t d0, input wide_t d1,
                                         input wide_t d2, input wide_t d3);
        case (i)
            0:       return d0 - d2;
            1:       return d1 + d2;
            2:       return d2 - d1;
            default: return d1 - d3;
        endcase
    endfunction

endpackage

// File: rtl/wino_f23_lane.sv
// Combinational Winograd F(2,3) datapath: transforms for S1 and element-wise products for S2.
module wino_f23_lane
    import wino_pkg::*;
#(
    parameter int DW = 10,
    localparam int UW = DW + 2,
    localparam int VW = DW + 1,
    localparam int PW = 2 * DW + 3
) (
    input  logic [3*DW-1:0]      g_taps,
    input  logic [4*DW-1:0]      d_tile,
    output logic signed [UW-1:0] u    [4],
    output logic signed [VW-1:0] v    [4],
    input  logic signed [UW-1:0] u_in [4],
    input  logic signed [VW-1:0] v_in [4],
    output logic signed [PW-1:0] m    [4]
);

    wide_t g_w [3];
    wide_t d_w [4];

    always_comb begin
        for (int i = 0; i < 3; i++) g_w[i] = wide_t'($signed(g_taps[i*DW +: DW]));
        for (int i = 0; i < 4; i++) d_w[i] = wide_t'($signed(d_tile[i*DW +: DW]));
        for (int i = 0; i < 4; i++) begin
            u[i] = UW'(filt_xform(i, g_w[0], g_w[1], g_w[2]));
            v[i] = VW'(data_xform(i, d_w[0], d_w[1], d_w[2], d_w[3]));
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) m[i] = PW'(u_in[i]) * PW'(v_in[i]);
    end

endmodule

// File: rtl/wino_f23_engine.sv
// Multi-channel Winograd F(2,3) engine: filter banks, tile capture, 3-stage pipeline,
// channel accumulator and a stallable output register.
module wino_f23_engine
    import wino_pkg::*;
#(
    parameter int DW = 10,
    parameter int CH = 1,
    localparam int OW  = ow_width(DW, CH),
    localparam int CIW = idx_width(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            g_we,
    input  logic [CIW-1:0]  g_ch,
    input  logic [3*DW-1:0] g_data,
    input  logic            d_valid,
    output logic            d_ready,
    input  logic [4*DW-1:0] d_data,
    input  logic            clr,
    output logic            y_valid,
    input  logic            y_ready,
    output logic [2*OW-1:0] y_data,
    output logic [CIW-1:0]  ch_idx
);

    localparam int UW = DW + 2;
    localparam int VW = DW + 1;
    localparam int PW = 2 * DW + 3;

    logic en, is_last;
    logic [3*DW-1:0] bank [CH];
    logic [3*DW-1:0] g_sel, g_p0;
    logic [4*DW-1:0] d_p0;
    logic vld_p0, vld_p1, vld_p2, last_p0, last_p1, last_p2;
    logic signed [UW-1:0] u_c [4], u_p1 [4];
    logic signed [VW-1:0] v_c [4], v_p1 [4];
    logic signed [PW-1:0] m_c [4], m_p2 [4];
    logic signed [OW-1:0] acc0, acc1, y0_t, y1_t, sum0, sum1;

    assign en      = !y_valid || y_ready;
    assign d_ready = en;
    assign is_last = (ch_idx == CIW'(CH - 1));

    always_comb begin
        g_sel = '0;
        for (int i = 0; i < CH; i++) if (ch_idx == CIW'(i)) g_sel = bank[i];
    end

    // A same-cycle write lands after the bank was sampled into g_p0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) bank[i] <= '0;
        end else if (g_we && !clr) begin
            for (int i = 0; i < CH; i++) if (g_ch == CIW'(i)) bank[i] <= g_data;
        end
    end

    wino_f23_lane #(.DW(DW)) u_lane (
        .g_taps (g_p0),
        .d_tile (d_p0),
        .u      (u_c),
        .v      (v_c),
        .u_in   (u_p1),
        .v_in   (v_p1),
        .m      (m_c)
    );

    // S0 capture -> S1 transforms -> S2 products
    always_ff @(posedge clk) begin
        if (en) begin
            d_p0 <= d_data;
            g_p0 <= g_sel;
            u_p1 <= u_c;
            v_p1 <= v_c;
            m_p2 <= m_c;
        end
    end

    // S3: output transform, exact halving undoes the 2x filter scaling
    always_comb begin
        y0_t = (OW'(m_p2[0]) + OW'(m_p2[1]) + OW'(m_p2[2])) >>> 1;
        y1_t = (OW'(m_p2[1]) - OW'(m_p2[2]) - OW'(m_p2[3])) >>> 1;
        sum0 = acc0 + y0_t;
        sum1 = acc1 + y1_t;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
            last_p0 <= 1'b0; last_p1 <= 1'b0; last_p2 <= 1'b0;
            acc0 <= '0; acc1 <= '0;
            y_data <= '0; y_valid <= 1'b0;
            ch_idx <= '0;
        end else if (clr) begin
            vld_p0 <= 1'b0; vld_p1 <= 1'b0; vld_p2 <= 1'b0;
            acc0 <= '0; acc1 <= '0;
            y_valid <= 1'b0;
            ch_idx <= '0;
        end else if (en) begin
            vld_p0 <= d_valid;  last_p0 <= is_last;
            vld_p1 <= vld_p0;   last_p1 <= last_p0;
            vld_p2 <= vld_p1;   last_p2 <= last_p1;
            if (d_valid) ch_idx <= is_last ? '0 : ch_idx + CIW'(1);
            y_valid <= vld_p2 && last_p2;
            if (vld_p2) begin
                if (last_p2) begin
                    y_data <= {sum1, sum0};
                    acc0 <= '0; acc1 <= '0;
                end else begin
                    acc0 <= sum0; acc1 <= sum1;
                end
            end
        end
    end

endmodule
